// File: rtl/uart_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and address layout.
package uart_pkg;

    // Loader FSM: count header, instruction words, data count header, data words, done
    typedef enum logic [2:0] {
        S_ICNT,
        S_IDATA,
        S_DCNT,
        S_DDATA,
        S_DONE
    } state_t;

    // Receiver FSM inside uart_rx_core
    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
    } rx_state_t;

    // Address bit 14 selects instruction ROM (0) or data RAM (1)
    localparam int MEM_SEL_BIT = 14;
    localparam int IDX_W       = 14;
    localparam int ADR_W       = 15;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, framing check.
// Emits a one-cycle byte_vld with byte_dat on a good stop bit, frame_err on a bad one.
module uart_rx_core import uart_pkg::*; #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       frame_err
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            vld_nxt, ferr_nxt;

    assign byte_dat = shift;

    // Synchronize the asynchronous line and keep one older sample for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver state, baud counter, bit counter and deserializer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= R_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            byte_vld  <= vld_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Next-state logic: start check at half a bit, then sample every full bit period
    always_comb begin
        rx_state_nxt = rx_state;
        cnt_nxt      = cnt + 1'b1;
        bit_nxt      = bit_idx;
        shift_nxt    = shift;
        vld_nxt      = 1'b0;
        ferr_nxt     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s2) rx_state_nxt = R_START;
            end
            R_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt      = '0;
                    bit_nxt      = '0;
                    // A start bit that is high again at mid-bit was only a glitch
                    rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s2, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    if (rx_s2) begin
                        vld_nxt      = 1'b1;
                        rx_state_nxt = R_IDLE;
                    end else begin
                        ferr_nxt     = 1'b1;
                        rx_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                // After a framing error, re-arm only once the line has returned high
                cnt_nxt = '0;
                if (rx_s2) rx_state_nxt = R_IDLE;
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses a count/words image for instruction ROM then data RAM,
// producing one-cycle word write strobes and a sticky done flag.
module uart_prog_loader import uart_pkg::*; #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int BAUD    = 128_000,
    parameter int IDLE_TO = 1_000_000
) (
    input  logic             upg_clk_i,
    input  logic             upg_rst_i,
    input  logic             upg_rx_i,
    output logic             upg_clk_o,
    output logic             upg_wen_o,
    output logic [ADR_W-1:0] upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             upg_err_o
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(IDLE_TO + 1);

    logic             byte_vld, frame_err;
    logic [7:0]       byte_dat;

    state_t           state, state_nxt;
    logic [1:0]       byte_cnt;
    logic [7:0]       cnt_lo;
    logic [IDX_W-1:0] word_cnt, word_idx, hdr_cnt;
    logic [23:0]      word_buf;
    logic [TW-1:0]    idle_cnt;
    logic             idle_run, timeout, take, wr_word, last_word;
    logic             wen;
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat;
    logic             err;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clk       (upg_clk_i),
        .rst       (upg_rst_i),
        .rx        (upg_rx_i),
        .byte_vld  (byte_vld),
        .byte_dat  (byte_dat),
        .frame_err (frame_err)
    );

    assign upg_clk_o  = upg_clk_i;
    assign upg_wen_o  = wen;
    assign upg_adr_o  = adr;
    assign upg_dat_o  = dat;
    assign upg_err_o  = err;
    assign upg_done_o = (state == S_DONE);

    // Loader state register
    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) state <= S_ICNT;
        else           state <= state_nxt;
    end

    // Next-state and event decode; an idle timeout overrides a byte arriving the same cycle
    always_comb begin
        idle_run  = (state == S_IDATA) || (state == S_DCNT) || (state == S_DDATA) ||
                    ((state == S_ICNT) && (byte_cnt == 2'd1));
        timeout   = idle_run && (idle_cnt == TW'(IDLE_TO - 1));
        take      = byte_vld && !timeout;
        hdr_cnt   = {byte_dat[5:0], cnt_lo};
        last_word = (word_idx == word_cnt - 14'd1);
        wr_word   = take && ((state == S_IDATA) || (state == S_DDATA)) && (byte_cnt == 2'd3);
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_ICNT;
        end else if (take) begin
            case (state)
                S_ICNT:  if (byte_cnt == 2'd1) state_nxt = (hdr_cnt == '0) ? S_DCNT : S_IDATA;
                S_DCNT:  if (byte_cnt == 2'd1) state_nxt = (hdr_cnt == '0) ? S_DONE : S_DDATA;
                S_IDATA: if (wr_word && last_word) state_nxt = S_DCNT;
                S_DDATA: if (wr_word && last_word) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Counters, header capture, write strobe/address/data and sticky error
    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            byte_cnt <= '0;
            cnt_lo   <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            idle_cnt <= '0;
            wen      <= 1'b0;
            adr      <= '0;
            dat      <= '0;
            err      <= 1'b0;
        end else begin
            wen <= wr_word;
            if (frame_err || timeout) err <= 1'b1;
            if (!idle_run || byte_vld || timeout) idle_cnt <= '0;
            else                                  idle_cnt <= idle_cnt + 1'b1;

            if (timeout) begin
                byte_cnt <= '0;
                word_idx <= '0;
            end else if (take) begin
                case (state)
                    S_ICNT, S_DCNT: begin
                        if (byte_cnt == 2'd0) begin
                            cnt_lo   <= byte_dat;
                            byte_cnt <= 2'd1;
                        end else begin
                            word_cnt <= hdr_cnt;
                            byte_cnt <= 2'd0;
                            word_idx <= '0;
                        end
                    end
                    S_IDATA, S_DDATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            adr[MEM_SEL_BIT]   <= (state == S_DDATA);
                            adr[IDX_W-1:0]     <= word_idx;
                            dat                <= {byte_dat, word_buf};
                            word_idx           <= last_word ? '0 : word_idx + 14'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Little-endian byte assembly; only the first three bytes of a word are held here
    always_ff @(posedge upg_clk_i) begin
        if (take && ((state == S_IDATA) || (state == S_DDATA)) && (byte_cnt != 2'd3))
            word_buf <= {byte_dat, word_buf[23:8]};
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized bench for uart_prog_loader; expected writes come from the image layout.
module tb_uart_prog_loader;
    import uart_pkg::*;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD    = 100_000;
    localparam int IDLE_TO = 1000;
    localparam int BITC    = CLK_HZ / BAUD;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        clk_o, wen, done, err;
    logic [14:0] adr;
    logic [31:0] dat;

    int tests = 0;
    int fails = 0;

    logic [14:0] obs_adr[$];
    logic [31:0] obs_dat[$];
    logic [14:0] exp_adr[$];
    logic [31:0] exp_dat[$];

    uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .IDLE_TO(IDLE_TO)) dut (
        .upg_clk_i  (clk),
        .upg_rst_i  (rst),
        .upg_rx_i   (rx),
        .upg_clk_o  (clk_o),
        .upg_wen_o  (wen),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_done_o (done),
        .upg_err_o  (err)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen by the memories
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            obs_adr.push_back(adr);
            obs_dat.push_back(dat);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BITC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BITC);
        end
        rx = stop;
        tick(BITC);
        rx = 1'b1;
        tick(BITC);
    endtask

    task automatic send_hdr(input logic [15:0] h);
        send_byte(h[7:0], 1'b1);
        send_byte(h[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic clear_obs();
        obs_adr.delete();
        obs_dat.delete();
        exp_adr.delete();
        exp_dat.delete();
    endtask

    task automatic expect_write(input logic [14:0] a, input logic [31:0] d);
        exp_adr.push_back(a);
        exp_dat.push_back(d);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, 32'(obs_adr.size()), 32'(exp_adr.size()));
        n = (obs_adr.size() < exp_adr.size()) ? obs_adr.size() : exp_adr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_adr%0d", tag, i), 32'(obs_adr[i]), 32'(exp_adr[i]));
            check($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
    endtask

    // Whole image: n ROM words then m RAM words, header top bits randomized (ignored by the loader)
    task automatic run_image(input int n, input int m);
        logic [31:0] w;
        send_hdr(16'(n) | (16'($urandom_range(0, 3)) << 14));
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            expect_write({1'b0, 14'(k)}, w);
            send_word(w);
        end
        send_hdr(16'(m) | (16'($urandom_range(0, 3)) << 14));
        for (int k = 0; k < m; k++) begin
            w = $urandom;
            expect_write({1'b1, 14'(k)}, w);
            send_word(w);
        end
        tick(20);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        rx  = 1'b1;
        tick(4);
        check("rst_wen",   32'(wen),       32'd0);
        check("rst_adr",   32'(adr),       32'd0);
        check("rst_dat",   dat,            32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_state", 32'(dut.state), 32'(S_ICNT));
        rst = 1'b0;
        tick(4);

        // Short low glitch on rx is rejected
        clear_obs();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(60);
        check("glitch_err",   32'(err),       32'd0);
        check("glitch_state", 32'(dut.state), 32'(S_ICNT));
        compare_writes("glitch");

        // Basic two-region image, loaded right after the glitch
        clear_obs();
        send_hdr(16'h0002);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        send_hdr(16'h0001);
        send_word(32'h01020304);
        tick(20);
        expect_write(15'h0000, 32'h12345678);
        expect_write(15'h0001, 32'hDEADBEEF);
        expect_write(15'h4000, 32'h01020304);
        compare_writes("img1");
        check("img1_done",     32'(done), 32'd1);
        check("img1_err",      32'(err),  32'd0);
        check("img1_hold_adr", 32'(adr),  32'h4000);
        check("img1_hold_dat", dat,       32'h01020304);

        // Empty image, then trailing bytes ignored in done
        do_reset();
        clear_obs();
        send_hdr(16'h0000);
        send_hdr(16'h0000);
        tick(20);
        check("empty_done", 32'(done), 32'd1);
        send_word(32'hDDCCBBAA);
        tick(20);
        compare_writes("empty");
        check("empty_done2", 32'(done), 32'd1);
        check("empty_adr",   32'(adr),  32'd0);
        check("empty_dat",   dat,       32'd0);
        check("empty_err",   32'(err),  32'd0);

        // Framing error byte is dropped, word continues with following good bytes
        do_reset();
        clear_obs();
        send_hdr(16'h0001);
        send_byte(8'h5A, 1'b0);
        send_word(32'h44332211);
        tick(20);
        expect_write(15'h0000, 32'h44332211);
        compare_writes("ferr");
        check("ferr_err",  32'(err),  32'd1);
        check("ferr_done", 32'(done), 32'd0);

        // Idle timeout mid-word aborts to the count header
        do_reset();
        clear_obs();
        send_hdr(16'h0001);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(IDLE_TO + 50);
        check("to_err",     32'(err),          32'd1);
        check("to_state",   32'(dut.state),    32'(S_ICNT));
        check("to_nowrite", 32'(obs_adr.size()), 32'd0);
        send_hdr(16'h0001);
        send_word(32'hDDCCBBAA);
        send_hdr(16'h0000);
        tick(20);
        expect_write(15'h0000, 32'hDDCCBBAA);
        compare_writes("to");
        check("to_done", 32'(done), 32'd1);

        // Asynchronous reset mid-byte in the data region
        do_reset();
        clear_obs();
        w = $urandom | 32'h1;
        send_hdr(16'h0001);
        send_word(w);
        send_hdr(16'h0001);
        send_byte(8'h3C, 1'b1);
        rx = 1'b0;
        tick(40);
        #3 rst = 1'b1;
        #1;
        check("arst_state_pre_dat", dat,       32'd0);
        check("arst_wen",           32'(wen),  32'd0);
        check("arst_adr",           32'(adr),  32'd0);
        check("arst_done",          32'(done), 32'd0);
        check("arst_err",           32'(err),  32'd0);
        rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        clear_obs();
        run_image($urandom_range(1, 4), $urandom_range(1, 3));
        compare_writes("arst_img");
        check("arst_img_done", 32'(done), 32'd1);
        check("arst_img_err",  32'(err),  32'd0);

        // Randomized images
        for (int r = 0; r < 3; r++) begin
            do_reset();
            clear_obs();
            run_image($urandom_range(0, 3), $urandom_range(0, 3));
            compare_writes($sformatf("rand%0d", r));
            check($sformatf("rand%0d_done", r), 32'(done), 32'd1);
            check($sformatf("rand%0d_err", r),  32'(err),  32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
